// File: rtl/gen_sec.sv
// gen_sec: serial frame transmitter (sync pattern, MSB-first data word, restart pattern).
// Define GEN_SEC_PARIDAD_EN to append an even-parity bit after the data word.
module gen_sec #(
    parameter logic [4:0] SECUENCIA    = 5'b10100,
    parameter logic [4:0] SEC_REINICIO = 5'b00000,
    parameter int         ANCHO        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inicio,
    input  logic [ANCHO-1:0] dato,
    output logic             s_out,
    output logic             ocupado,
    output logic             listo
);
    localparam int CW    = $clog2(ANCHO > 5 ? ANCHO : 5);
    localparam int S_INI = 0;
    localparam int S_PRE = 1;
    localparam int S_DAT = 2;
    localparam int S_REI = 3;
`ifdef GEN_SEC_PARIDAD_EN
    localparam int S_PAR = 4;
    localparam int NS    = 5;
`else
    localparam int NS    = 4;
`endif
    localparam logic [CW-1:0] LD_PAT = CW'(4);
    localparam logic [CW-1:0] LD_DAT = CW'(ANCHO - 1);

    logic [NS-1:0]    state, nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [ANCHO-1:0] sr, sr_nxt;
    logic             last, pat;
    logic             s_out_d, ocupado_d, listo_d;
`ifdef GEN_SEC_PARIDAD_EN
    logic             par, par_nxt;
`endif

    assign last = cnt == '0;

    // Outputs are computed from the next state so the line bit is registered alongside it.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state   <= NS'(1);
            cnt     <= '0;
            sr      <= '0;
            s_out   <= 1'b0;
            ocupado <= 1'b0;
            listo   <= 1'b0;
        end else begin
            state   <= nxt;
            cnt     <= cnt_nxt;
            sr      <= sr_nxt;
            s_out   <= s_out_d;
            ocupado <= ocupado_d;
            listo   <= listo_d;
        end

`ifdef GEN_SEC_PARIDAD_EN
    always_ff @(posedge clk or negedge rst)
        if (!rst) par <= 1'b0;
        else par <= par_nxt;
`endif

    always_comb begin
        nxt     = '0;
        cnt_nxt = cnt - 1'b1;
        sr_nxt  = sr;
`ifdef GEN_SEC_PARIDAD_EN
        par_nxt = par;
`endif
        if (state[S_PRE]) begin
            nxt[S_PRE] = !last;
            nxt[S_DAT] = last;
            cnt_nxt    = last ? LD_DAT : cnt_nxt;
        end else if (state[S_DAT]) begin
            sr_nxt = sr << 1;
            if (!last) nxt[S_DAT] = 1'b1;
            else begin
`ifdef GEN_SEC_PARIDAD_EN
                nxt[S_PAR] = 1'b1;
                cnt_nxt    = '0;
`else
                nxt[S_REI] = 1'b1;
                cnt_nxt    = LD_PAT;
`endif
            end
`ifdef GEN_SEC_PARIDAD_EN
        end else if (state[S_PAR]) begin
            nxt[S_REI] = 1'b1;
            cnt_nxt    = LD_PAT;
`endif
        end else if (state[S_REI] && !last) begin
            nxt[S_REI] = 1'b1;
        end else if ((state[S_INI] || state[S_REI]) && inicio) begin
            // Accept from idle or on the last restart bit for gap-free back-to-back frames.
            nxt[S_PRE] = 1'b1;
            cnt_nxt    = LD_PAT;
            sr_nxt     = dato;
`ifdef GEN_SEC_PARIDAD_EN
            par_nxt    = ^dato;
`endif
        end else begin
            nxt[S_INI] = 1'b1;
            cnt_nxt    = '0;
        end
    end

    always_comb begin
        pat       = |((nxt[S_PRE] ? SECUENCIA : SEC_REINICIO) & (5'b00001 << cnt_nxt));
`ifdef GEN_SEC_PARIDAD_EN
        s_out_d   = nxt[S_DAT] ? sr_nxt[ANCHO-1] : nxt[S_PAR] ? par_nxt : (nxt[S_PRE] | nxt[S_REI]) & pat;
`else
        s_out_d   = nxt[S_DAT] ? sr_nxt[ANCHO-1] : (nxt[S_PRE] | nxt[S_REI]) & pat;
`endif
        ocupado_d = !nxt[S_INI];
        listo_d   = nxt[S_REI] && cnt_nxt == '0;
    end
endmodule

// File: tb/tb_gen_sec.sv
// tb_gen_sec: directed frames checked every cycle against a frame-queue model of the line.
module tb_gen_sec;
    localparam logic [4:0] SEC = 5'b10100;
    localparam logic [4:0] REI = 5'b00000;
    localparam int W = 8;
`ifdef GEN_SEC_PARIDAD_EN
    localparam int N = 11 + W;
`else
    localparam int N = 10 + W;
`endif

    logic clk = 1'b0, rst = 1'b1, inicio = 1'b0;
    logic [W-1:0] dato = '0;
    logic s_out, ocupado, listo;
    int errors = 0, checks = 0;
    int rem = 0;
    logic [N-1:0] frame = '0;
    bit chk_en = 1'b0;

    gen_sec #(.SECUENCIA(SEC), .SEC_REINICIO(REI), .ANCHO(W)) dut (
        .clk(clk), .rst(rst), .inicio(inicio), .dato(dato),
        .s_out(s_out), .ocupado(ocupado), .listo(listo)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] build(input logic [W-1:0] d);
`ifdef GEN_SEC_PARIDAD_EN
        return {SEC, d, ^d, REI};
`else
        return {SEC, d, REI};
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // rem = frame bits still to appear on the line, counting the one currently shown.
    always @(posedge clk or negedge rst)
        if (!rst) rem <= 0;
        else if (rem <= 1 && inicio) begin
            frame <= build(dato);
            rem   <= N;
        end else if (rem > 0) rem <= rem - 1;

    always @(negedge clk)
        if (chk_en) begin
            chk("s_out", s_out, rem > 0 ? frame[rem-1] : 1'b0);
            chk("ocupado", ocupado, rem > 0);
            chk("listo", listo, rem == 1);
        end

    task automatic run_frame(input logic [W-1:0] d, input int p1, input int p2,
                             output logic [N-1:0] bits, output int busy, output int lc);
        bits = '0; busy = 0; lc = 0;
        inicio = 1'b1; dato = d;
        @(negedge clk);
        inicio = 1'b0;
        for (int k = 1; k <= N + 2; k++) begin
            if (k <= N) bits[N-k] = s_out;
            busy += ocupado;
            if (listo) lc = k;
            inicio = (k == p1 || k == p2);
            @(negedge clk);
        end
        inicio = 1'b0;
    endtask

    initial begin
        logic [N-1:0] bits;
        int busy, lc;
        bit seen;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_s_out", s_out, 0);
        chk("rst_ocupado", ocupado, 0);
        chk("rst_listo", listo, 0);
        rst = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        run_frame(8'hA5, 0, 0, bits, busy, lc);
`ifdef GEN_SEC_PARIDAD_EN
        chk("a5_bits", bits, 19'b10100_10100101_0_00000);
`else
        chk("a5_bits", bits, 18'b10100_10100101_00000);
`endif
        chk("a5_busy", busy, N);
        chk("a5_listo_cycle", lc, N);

        inicio = 1'b1; dato = 8'hFF;
        @(negedge clk);
        dato = 8'h00;
        busy = 0;
        for (int k = 1; k <= 2 * N; k++) begin
            busy += ocupado;
            if (k == N + 1) begin
                chk("b2b_first_bit", s_out, 1);
                inicio = 1'b0;
            end
            @(negedge clk);
        end
        chk("b2b_busy", busy, 2 * N);
        repeat (2) @(negedge clk);

        run_frame(8'h3C, 2, 8, bits, busy, lc);
`ifdef GEN_SEC_PARIDAD_EN
        chk("ign_bits", bits, 19'b10100_00111100_0_00000);
`else
        chk("ign_bits", bits, 18'b10100_00111100_00000);
`endif
        chk("ign_busy", busy, N);

        inicio = 1'b1; dato = 8'hB4;
        @(negedge clk);
        inicio = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort_pre_s_out", s_out, 1);
        #2 rst = 1'b0;
        #1;
        chk("abort_s_out", s_out, 0);
        chk("abort_ocupado", ocupado, 0);
        chk("abort_listo", listo, 0);
        @(negedge clk);
        rst = 1'b1;
        run_frame(8'h5A, 0, 0, bits, busy, lc);
`ifdef GEN_SEC_PARIDAD_EN
        chk("after_abort_bits", bits, 19'b10100_01011010_0_00000);
`else
        chk("after_abort_bits", bits, 18'b10100_01011010_00000);
`endif
        chk("after_abort_busy", busy, N);

        run_frame(8'h07, 0, 0, bits, busy, lc);
`ifdef GEN_SEC_PARIDAD_EN
        chk("par_bit14", bits[N-14], 1);
        chk("par_bits", bits, 19'b10100_00000111_1_00000);
`else
        chk("bits_07", bits, 18'b10100_00000111_00000);
`endif
        chk("len_07", busy, N);
        chk("listo_07", lc, N);

        run_frame(8'h00, 0, 0, bits, busy, lc);
        seen = 1'b0;
        for (int i = 0; i + 5 <= N; i++) if (bits[i+:5] == SEC) seen = 1'b1;
        chk("loop_sync_seen", seen, 1);
        chk("loop_restart_tail", bits[4:0], REI);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
